oled_frame_streamer: RTL and testbench

- Downstream consumer of the image controller's 1024-byte `imagem` bus.
- Serialises the selected frame to a 128x64 SSD1306 OLED over 4-wire SPI (mode 0, MSB first).
- Handles the panel reset pulse, a per-frame address-window command prefix, and frame-request buffering.
- Sole driver of the panel pins in the Tamagotchi top level.

---
 rtl/oled_pkg.sv | 33 +++
 rtl/oled_frame_streamer_spi_byte_tx.sv | 77 +++++++
 rtl/oled_frame_streamer.sv | 182 ++++++++++++++++++
 tb/tb_oled_frame_streamer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// oled_pkg: shared types and constant tables for the SSD1306 frame streamer.
// Holds the FSM state type, the per-frame address-window prefix and the init ROM.
package oled_pkg;

  typedef enum logic [2:0] {
    ST_PANEL_RST,
    ST_PANEL_WAIT,
    ST_INIT,
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } state_e;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  localparam int ADDR_LEN = 8;
  localparam logic [7:0] ADDR_CMD [ADDR_LEN] = '{
    8'h20, 8'h00, 8'h21, 8'h00,
    8'h7F, 8'h22, 8'h00, 8'h07
  };

  localparam int INIT_LEN = 25;
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F,
    8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
    8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA,
    8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
    8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
  };

endpackage

// File: rtl/oled_frame_streamer_spi_byte_tx.sv
// spi_byte_tx: SPI mode-0 byte shifter, MSB first, sclk half-period CLK_DIV.
// Ports: start/byte_in load a byte (also on byte_done for gapless bursts);
// sclk/mosi drive the bus, busy while shifting, byte_done on the last fall.
module spi_byte_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       sclk,
  output logic       mosi,
  output logic       busy,
  output logic       byte_done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          sclk_q, sclk_d;
  logic          busy_q, busy_d;
  logic          tick;

  assign tick      = busy_q && (cnt_q == CW'(CLK_DIV - 1));
  assign byte_done = tick && sclk_q && (bit_q == 3'd7);

  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    sclk_d  = sclk_q;
    busy_d  = busy_q;
    if (tick) begin
      cnt_d  = '0;
      sclk_d = !sclk_q;
      // next bit goes out on the falling edge
      if (sclk_q) begin
        bit_d   = bit_q + 3'd1;
        shift_d = {shift_q[6:0], 1'b0};
      end
    end else if (busy_q) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (byte_done) busy_d = 1'b0;
    // reload on the final fall keeps bytes back-to-back
    if (start && (!busy_q || byte_done)) begin
      shift_d = byte_in;
      bit_d   = '0;
      cnt_d   = '0;
      sclk_d  = 1'b0;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sclk_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sclk_q  <= sclk_d;
      busy_q  <= busy_d;
    end
  end

  assign sclk = sclk_q;
  assign mosi = shift_q[7];
  assign busy = busy_q;

endmodule

// File: rtl/oled_frame_streamer.sv
// oled_frame_streamer: streams the 1024-byte imagem frame to an SSD1306 over SPI.
// Ports: imagem/atualizar in; pronto, frame_done, oled_* pins out. OLED_INIT_SEQ_EN adds init ROM.
module oled_frame_streamer
  import oled_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int RST_CYCLES = 1000,
  parameter int N_BYTES    = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*N_BYTES-1:0] imagem,
  input  logic                 atualizar,
  output logic                 pronto,
  output logic                 frame_done,
  output logic                 oled_sclk,
  output logic                 oled_mosi,
  output logic                 oled_dc,
  output logic                 oled_cs_n,
  output logic                 oled_res_n
);

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int AW = $clog2(8 * N_BYTES);

  state_e        state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [10:0]   idx_q, idx_d;
  logic          pending_q, pending_d;
  logic          res_n_q, res_n_d;
  logic          cs_n_q, cs_n_d;
  logic          dc_q, dc_d;
  logic          pronto_q, pronto_d;
  logic          frame_done_q, frame_done_d;

  logic          tx_start, tx_busy, tx_done;
  logic [7:0]    tx_byte;
  logic [10:0]   idx_nx;
  logic [AW-1:0] bit_base;
  logic          go;

  assign idx_nx   = idx_q + 11'd1;
  assign bit_base = AW'(idx_nx) << 3;

  always_comb begin
    state_d      = state_q;
    rcnt_d       = rcnt_q;
    idx_d        = idx_q;
    pending_d    = pending_q | atualizar;
    frame_done_d = 1'b0;
    tx_start     = 1'b0;
    tx_byte      = 8'h00;
    go           = (atualizar || pending_q) && !tx_busy;
    unique case (state_q)
      ST_PANEL_RST: begin
        rcnt_d = rcnt_q + 1'b1;
        if (rcnt_q == RW'(RST_CYCLES - 1)) begin
          rcnt_d  = '0;
          state_d = ST_PANEL_WAIT;
        end
      end
      ST_PANEL_WAIT: begin
        rcnt_d = rcnt_q + 1'b1;
        if (rcnt_q == RW'(RST_CYCLES - 1)) begin
          rcnt_d = '0;
`ifdef OLED_INIT_SEQ_EN
          state_d  = ST_INIT;
          idx_d    = '0;
          tx_start = 1'b1;
          tx_byte  = INIT_ROM[0];
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef OLED_INIT_SEQ_EN
      ST_INIT: begin
        if (tx_done) begin
          if (idx_q == 11'(INIT_LEN - 1)) begin
            state_d = ST_IDLE;
          end else begin
            idx_d    = idx_nx;
            tx_start = 1'b1;
            tx_byte  = INIT_ROM[idx_nx[4:0]];
          end
        end
      end
`endif
      // DONE chains straight into the next burst when a
      // request is waiting, so cs_n is high for one cycle
      ST_IDLE, ST_DONE: begin
        if (go) begin
          state_d   = ST_ADDR;
          idx_d     = '0;
          pending_d = 1'b0;
          tx_start  = 1'b1;
          tx_byte   = ADDR_CMD[0];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (tx_done) begin
          if (idx_q == 11'(ADDR_LEN - 1)) begin
            state_d  = ST_DATA;
            idx_d    = '0;
            tx_start = 1'b1;
            tx_byte  = imagem[7:0];
          end else begin
            idx_d    = idx_nx;
            tx_start = 1'b1;
            tx_byte  = ADDR_CMD[idx_nx[2:0]];
          end
        end
      end
      ST_DATA: begin
        if (tx_done) begin
          if (idx_q == 11'(N_BYTES - 1)) begin
            state_d      = ST_DONE;
            frame_done_d = 1'b1;
          end else begin
            idx_d    = idx_nx;
            tx_start = 1'b1;
            tx_byte  = imagem[bit_base +: 8];
          end
        end
      end
      default: state_d = ST_PANEL_RST;
    endcase
  end

  always_comb begin
    res_n_d  = (state_d != ST_PANEL_RST);
    cs_n_d   = !(state_d inside {ST_INIT, ST_ADDR, ST_DATA});
    dc_d     = (state_d == ST_DATA) ? DC_DATA : DC_CMD;
    pronto_d = (state_q == ST_IDLE) && !pending_q && !atualizar;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_PANEL_RST;
      rcnt_q       <= '0;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      res_n_q      <= 1'b0;
      cs_n_q       <= 1'b1;
      dc_q         <= 1'b0;
      pronto_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rcnt_q       <= rcnt_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      res_n_q      <= res_n_d;
      cs_n_q       <= cs_n_d;
      dc_q         <= dc_d;
      pronto_q     <= pronto_d;
      frame_done_q <= frame_done_d;
    end
  end

  spi_byte_tx #(
    .CLK_DIV(CLK_DIV)
  ) u_tx (
    .clk      (clk),
    .rst      (rst),
    .start    (tx_start),
    .byte_in  (tx_byte),
    .sclk     (oled_sclk),
    .mosi     (oled_mosi),
    .busy     (tx_busy),
    .byte_done(tx_done)
  );

  assign pronto     = pronto_q;
  assign frame_done = frame_done_q;
  assign oled_dc    = dc_q;
  assign oled_cs_n  = cs_n_q;
  assign oled_res_n = res_n_q;

endmodule

// File: tb/tb_oled_frame_streamer.sv
// tb_oled_frame_streamer: scoreboard bench for oled_frame_streamer.
// Decodes the SPI bus and frame_done against a queue of expected bytes/times.
module tb_oled_frame_streamer;

  localparam int CLK_DIV    = 1;
  localparam int RST_CYCLES = 10;
  localparam int N_BYTES    = 1024;
  localparam int BYTE_CYC   = 16 * CLK_DIV;
  localparam int FRAME_CYC  = (8 + N_BYTES) * BYTE_CYC + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [8*N_BYTES-1:0] imagem;
  logic                 atualizar;
  logic                 pronto, frame_done;
  logic                 oled_sclk, oled_mosi;
  logic                 oled_dc, oled_cs_n, oled_res_n;

  always #5 clk = ~clk;

  oled_frame_streamer #(
    .CLK_DIV   (CLK_DIV),
    .RST_CYCLES(RST_CYCLES),
    .N_BYTES   (N_BYTES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .imagem    (imagem),
    .atualizar (atualizar),
    .pronto    (pronto),
    .frame_done(frame_done),
    .oled_sclk (oled_sclk),
    .oled_mosi (oled_mosi),
    .oled_dc   (oled_dc),
    .oled_cs_n (oled_cs_n),
    .oled_res_n(oled_res_n)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  int fd_q[$];
  int fd_count = 0;
  int pronto_hits = 0;
  int dc_glitch = 0;
  logic watch = 1'b0;

  logic [7:0] cmd_ref [8] = '{
    8'h20, 8'h00, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07
  };

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  task automatic push_frame();
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, cmd_ref[i]});
    for (int k = 0; k < N_BYTES; k++)
      exp_q.push_back({1'b1, imagem[8*k +: 8]});
  endtask

  // SPI / frame_done monitor
  initial begin
    logic psclk;
    int bitn;
    logic [7:0] sh;
    logic dcc;
    psclk = 1'b0;
    bitn = 0;
    sh = '0;
    dcc = 1'b0;
    forever begin
      @(negedge clk);
      if (oled_cs_n) begin
        bitn = 0;
      end else begin
        if (bitn > 0 && oled_dc !== dcc) dc_glitch++;
        if (oled_sclk && !psclk) begin
          if (bitn == 0) dcc = oled_dc;
          sh = {sh[6:0], oled_mosi};
          bitn++;
          if (bitn == 8) begin
            bitn = 0;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL spi_byte_extra: got 0x%0h expected none",
                       {dcc, sh});
            end else begin
              check("spi_byte", 32'({dcc, sh}), 32'(exp_q.pop_front()));
            end
          end
        end
      end
      psclk = oled_sclk;
      if (frame_done === 1'b1) begin
        fd_count++;
        if (fd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_done_extra: got cycle %0d expected none", cyc);
        end else begin
          check("frame_done_cycle", cyc, fd_q.pop_front());
        end
      end
      if (watch && pronto === 1'b1) pronto_hits++;
    end
  end

  task automatic release_check();
    int c0, res_rise, pr_rise, idle_bad;
    @(posedge clk);
    #1;
    rst = 1'b0;
    c0 = cyc;
    res_rise = -1;
    pr_rise = -1;
    idle_bad = 0;
    for (int i = 0; i < 3 * RST_CYCLES; i++) begin
      @(negedge clk);
      if (res_rise < 0 && oled_res_n === 1'b1) res_rise = cyc - c0;
      if (pr_rise < 0 && pronto === 1'b1) pr_rise = cyc - c0;
      if (oled_sclk !== 1'b0 || oled_cs_n !== 1'b1) idle_bad++;
    end
    check("res_n_rise", res_rise, RST_CYCLES);
    check("pronto_rise", pr_rise, 2 * RST_CYCLES + 1);
    check("idle_bus", idle_bad, 0);
  endtask

  task automatic wait_fd(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 2 * FRAME_CYC);
    if (frame_done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: got timeout expected frame_done", name);
    end
  endtask

  task automatic goto_cycle(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int t0, tb_done, pulse_at[3];
    pulse_at = '{100, 200, 300};
    rst = 1'b1;
    atualizar = 1'b0;
    for (int i = 0; i < N_BYTES / 4; i++) imagem[32*i +: 32] = $urandom;
    imagem[7:0] = 8'hA5;
    imagem[8*(N_BYTES-1) +: 8] = 8'h3C;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sclk", oled_sclk, 0);
    check("rst_mosi", oled_mosi, 0);
    check("rst_dc", oled_dc, 0);
    check("rst_cs_n", oled_cs_n, 1);
    check("rst_res_n", oled_res_n, 0);
    check("rst_pronto", pronto, 0);
    check("rst_frame_done", frame_done, 0);

    release_check();

    // frame A
    @(posedge clk);
    #1;
    t0 = cyc;
    atualizar = 1'b1;
    push_frame();
    fd_q.push_back(t0 + FRAME_CYC);
    @(posedge clk);
    #1;
    atualizar = 1'b0;
    watch = 1'b1;

    // three merged requests during A -> one extra frame
    foreach (pulse_at[p]) begin
      goto_cycle(t0 + 1 + (8 + pulse_at[p]) * BYTE_CYC + 5);
      atualizar = 1'b1;
      if (p == 0) begin
        push_frame();
        fd_q.push_back(t0 + 2 * FRAME_CYC);
      end
      @(posedge clk);
      #1;
      atualizar = 1'b0;
    end

    wait_fd("frame_a_done");
    check("gap_a_cs_high", oled_cs_n, 1);
    check("queue_after_a", exp_q.size(), 8 + N_BYTES);
    @(negedge clk);
    check("gap_a_cs_low", oled_cs_n, 0);
    check("gap_a_dc_cmd", oled_dc, 0);

    // frame B: request in its DONE cycle
    wait_fd("frame_b_done");
    tb_done = cyc;
    check("queue_after_b", exp_q.size(), 0);
    atualizar = 1'b1;
    push_frame();
    @(negedge clk);
    atualizar = 1'b0;
    check("gap_b_cs_low", oled_cs_n, 0);

    // abort frame C at data byte 500
    goto_cycle(tb_done + 1 + (8 + 500) * BYTE_CYC + 2);
    rst = 1'b1;
    exp_q.delete();
    watch = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_cs_n", oled_cs_n, 1);
    check("abort_res_n", oled_res_n, 0);
    check("abort_sclk", oled_sclk, 0);

    release_check();
    repeat (40) @(negedge clk);
    check("frame_done_count", fd_count, 2);
    check("frame_done_left", fd_q.size(), 0);
    check("pronto_busy_low", pronto_hits, 0);
    check("dc_stable", dc_glitch, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
